header_reader: RTL and testbench

- Streaming JPEG header parser at the front of the decompression accelerator.
- Consumes the raw JPEG file as 32-bit words, one word per clock, big-endian: byte0 = data_in[31:24], byte3 = data_in[7:0].
- Finds SOI and APP0, then walks marker segments by their length fields.
- Raises found_cutoff at the first byte of entropy-coded data, i.e. the end of the SOS header.

---
 rtl/jpeg_pkg.sv | 64 ++++++
 rtl/header_byte_step.sv | 117 +++++++++++
 rtl/header_reader.sv | 92 +++++++++
 tb/tb_header_reader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// -----------------------------------------------------------------------------
// jpeg_pkg
// Shared types and constants for the JPEG header parser.
//   hdr_state_t : byte-walker states
//   hdr_flags_t : sticky result flags (jpeg_valid, found_app0, found_cutoff)
//   hdr_ctx_t   : complete parser context carried from byte to byte and
//                 registered once per word
//   MRK_*       : marker codes (the byte following the FF prefix)
// -----------------------------------------------------------------------------
package jpeg_pkg;

    typedef enum logic [2:0] {
        S_SOI    = 3'd0,
        S_MARK   = 3'd1,
        S_CODE   = 3'd2,
        S_LEN_HI = 3'd3,
        S_LEN_LO = 3'd4,
        S_SKIP   = 3'd5,
        S_DONE   = 3'd6
    } hdr_state_t;

    localparam logic [7:0] MRK_PREFIX = 8'hFF;
    localparam logic [7:0] MRK_SOI    = 8'hD8;
    localparam logic [7:0] MRK_EOI    = 8'hD9;
    localparam logic [7:0] MRK_APP0   = 8'hE0;
    localparam logic [7:0] MRK_DQT    = 8'hDB;
    localparam logic [7:0] MRK_DHT    = 8'hC4;
    localparam logic [7:0] MRK_SOF0   = 8'hC0;
    localparam logic [7:0] MRK_SOS    = 8'hDA;
    localparam logic [7:0] MRK_STUFF  = 8'h00;
    localparam logic [7:0] MRK_TEM    = 8'h01;

    // Smallest legal segment length: the length field counts its own two bytes.
    localparam logic [15:0] MIN_SEG_LEN = 16'd2;

    typedef struct packed {
        logic jpeg_valid;
        logic found_app0;
        logic found_cutoff;
    } hdr_flags_t;

    typedef struct packed {
        hdr_state_t  state;
        logic        prev_ff;   // previous byte was FF while hunting for SOI
        logic [7:0]  len_hi;    // high byte of the segment length
        logic [15:0] skip;      // payload bytes still to discard
        logic        sos_seg;   // current segment is the cutoff segment
        hdr_flags_t  flags;
    } hdr_ctx_t;

    // Codes that stand alone with no length field: stuffing, TEM, RST0..RST7.
    function automatic logic is_standalone(input logic [7:0] code);
        is_standalone = (code == MRK_STUFF) || (code == MRK_TEM) ||
                        (code[7:3] == 5'b11010);
    endfunction

    function automatic hdr_ctx_t ctx_reset();
        hdr_ctx_t c;
        c       = '0;
        c.state = S_SOI;
        return c;
    endfunction

endpackage

// File: rtl/header_byte_step.sv
// -----------------------------------------------------------------------------
// header_byte_step
// Purely combinational single-byte step of the JPEG header walker.
// Ports:
//   ctx_in  : parser context before this byte
//   byte_in : one byte of the JPEG stream
//   ctx_out : parser context after this byte
// Parameters:
//   CUTOFF_CODE : marker whose segment end raises found_cutoff
//   APP0_CODE   : marker that raises found_app0
// -----------------------------------------------------------------------------
module header_byte_step
    import jpeg_pkg::*;
#(
    parameter logic [7:0] CUTOFF_CODE = 8'hDA,
    parameter logic [7:0] APP0_CODE   = 8'hE0
) (
    input  hdr_ctx_t   ctx_in,
    input  logic [7:0] byte_in,
    output hdr_ctx_t   ctx_out
);

    logic [15:0] seg_len;
    logic        seg_end;

    always_comb begin
        ctx_out         = ctx_in;
        ctx_out.prev_ff = 1'b0;
        seg_len         = {ctx_in.len_hi, byte_in};
        seg_end         = 1'b0;

        case (ctx_in.state)
            S_SOI: begin
                if (ctx_in.prev_ff && (byte_in == MRK_SOI)) begin
                    ctx_out.flags.jpeg_valid = 1'b1;
                    ctx_out.state            = S_MARK;
                end else begin
                    // prev_ff survives word boundaries via the context register
                    ctx_out.prev_ff = (byte_in == MRK_PREFIX);
                end
            end

            S_MARK: begin
                if (byte_in == MRK_PREFIX) begin
                    ctx_out.state = S_CODE;
                end
            end

            S_CODE: begin
                if (byte_in == MRK_PREFIX) begin
                    ctx_out.state = S_CODE;
                end else if (is_standalone(byte_in)) begin
                    ctx_out.state = S_MARK;
                end else if (byte_in == MRK_EOI) begin
                    // Back to hunting for a new image; flags stay sticky.
                    ctx_out.state = S_SOI;
                end else if (byte_in == MRK_SOI) begin
                    ctx_out.flags.jpeg_valid = 1'b1;
                    ctx_out.state            = S_MARK;
                end else begin
                    ctx_out.state = S_LEN_HI;
                    if (byte_in == APP0_CODE) begin
                        ctx_out.flags.found_app0 = 1'b1;
                    end
                    if (byte_in == CUTOFF_CODE) begin
                        ctx_out.sos_seg = 1'b1;
                    end
                end
            end

            S_LEN_HI: begin
                ctx_out.len_hi = byte_in;
                ctx_out.state  = S_LEN_LO;
            end

            S_LEN_LO: begin
                // Lengths below 2 are malformed; clamp so the subtraction
                // never wraps into a 64K-byte skip.
                if (seg_len < MIN_SEG_LEN) begin
                    seg_len = MIN_SEG_LEN;
                end
                ctx_out.skip = seg_len - MIN_SEG_LEN;
                if (ctx_out.skip == 16'd0) begin
                    seg_end = 1'b1;
                end else begin
                    ctx_out.state = S_SKIP;
                end
            end

            S_SKIP: begin
                // Payload bytes are opaque: an FF here is data, not a marker.
                ctx_out.skip = ctx_in.skip - 16'd1;
                if (ctx_out.skip == 16'd0) begin
                    seg_end = 1'b1;
                end
            end

            S_DONE: begin
                ctx_out.state = S_DONE;
            end

            default: begin
                ctx_out.state = S_SOI;
            end
        endcase

        if (seg_end) begin
            if (ctx_out.sos_seg) begin
                ctx_out.flags.found_cutoff = 1'b1;
                ctx_out.state              = S_DONE;
            end else begin
                ctx_out.state = S_MARK;
            end
        end
    end

endmodule

// File: rtl/header_reader.sv
// -----------------------------------------------------------------------------
// header_reader
// Streaming JPEG header parser. Consumes one big-endian 32-bit word per clock
// (byte0 = data_in[31:24]) and walks markers and segment lengths until the end
// of the cutoff (SOS) segment header.
// Ports:
//   clk          : rising-edge clock
//   rst          : asynchronous active-low reset
//   data_in      : JPEG word, sampled every edge while out of reset
//   jpeg_valid   : sticky, FFD8 seen
//   found_app0   : sticky, APP0 marker seen after SOI
//   found_cutoff : sticky, header consumed, entropy-coded data begins
// Build option:
//   HEADER_READER_DEBUG_EN : when defined, a simulation-only block prints
//   every registered state change with state name, marker code and time.
// -----------------------------------------------------------------------------
module header_reader
    import jpeg_pkg::*;
#(
    parameter logic [7:0] CUTOFF_CODE = 8'hDA,
    parameter logic [7:0] APP0_CODE   = 8'hE0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    output logic        jpeg_valid,
    output logic        found_app0,
    output logic        found_cutoff
);

    hdr_ctx_t ctx_q;
    hdr_ctx_t ctx_d;

    // chain[0] is the registered context, chain[4] the context after byte3.
    hdr_ctx_t chain [0:4];

    assign chain[0] = ctx_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            header_byte_step #(
                .CUTOFF_CODE (CUTOFF_CODE),
                .APP0_CODE   (APP0_CODE)
            ) u_step (
                .ctx_in  (chain[gi]),
                .byte_in (data_in[31-8*gi -: 8]),
                .ctx_out (chain[gi+1])
            );
        end
    endgenerate

    always_comb begin
        ctx_d = chain[4];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctx_q <= ctx_reset();
        end else begin
            ctx_q <= ctx_d;
        end
    end

    assign jpeg_valid   = ctx_q.flags.jpeg_valid;
    assign found_app0   = ctx_q.flags.found_app0;
    assign found_cutoff = ctx_q.flags.found_cutoff;

`ifdef HEADER_READER_DEBUG_EN
    // Most recent marker code in this word: the byte that entered a step
    // while that step was sitting in S_CODE.
    logic [7:0] dbg_code;

    always_comb begin
        dbg_code = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (chain[i].state == S_CODE) begin
                dbg_code = data_in[31-8*i -: 8];
            end
        end
    end

    always @(posedge clk) begin
        if (rst && (ctx_d.state != ctx_q.state)) begin
            $display("header_reader: %s -> %s code=%02h t=%0t",
                     ctx_q.state.name(), ctx_d.state.name(), dbg_code, $time);
        end
    end
`else
`endif

endmodule

// File: tb/tb_header_reader.sv
// -----------------------------------------------------------------------------
// tb_header_reader
// Directed tests for header_reader, one task per scenario.
// -----------------------------------------------------------------------------
module tb_header_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        jpeg_valid;
    logic        found_app0;
    logic        found_cutoff;

    int assert_count = 0;
    int fail_count   = 0;

    header_reader #(
        .CUTOFF_CODE (8'hDA),
        .APP0_CODE   (8'hE0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .jpeg_valid   (jpeg_valid),
        .found_app0   (found_app0),
        .found_cutoff (found_cutoff)
    );

    always #5 clk = ~clk;

    task automatic reset_dut();
        rst     = 1'b0;
        data_in = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Present one word for exactly one rising edge, then settle.
    task automatic send(input logic [31:0] w);
        data_in = w;
        @(posedge clk);
        #1;
        $display("word %08h -> jv=%b app0=%b cutoff=%b",
                 w, jpeg_valid, found_app0, found_cutoff);
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        data_in = 32'hFFD8FFE0;   // must be ignored while in reset
        repeat (3) @(posedge clk);
        #1;
        if ({jpeg_valid, found_app0, found_cutoff} !== 3'b000) begin
            $display("FAIL reset flags got %b want 000",
                     {jpeg_valid, found_app0, found_cutoff});
            fail_count++;
        end
        assert_count++;
    endtask

    task automatic test_soi_app0();
        reset_dut();
        send(32'hFFD8FFE0);
        if ({jpeg_valid, found_app0, found_cutoff} !== 3'b110) begin
            $display("FAIL soi_app0 flags got %b want 110",
                     {jpeg_valid, found_app0, found_cutoff});
            fail_count++;
        end
        assert_count++;
    endtask

    task automatic test_split_soi();
        reset_dut();
        send(32'h000000FF);
        if (jpeg_valid !== 1'b0) begin
            $display("FAIL split_soi_first jv got %b want 0", jpeg_valid);
            fail_count++;
        end
        assert_count++;
        send(32'hD8000000);
        if ({jpeg_valid, found_app0, found_cutoff} !== 3'b100) begin
            $display("FAIL split_soi_second flags got %b want 100",
                     {jpeg_valid, found_app0, found_cutoff});
            fail_count++;
        end
        assert_count++;
    endtask

    // APP0 length 0x0010 carries an FFDA000C inside its payload, then EOI,
    // then a real zero-payload SOS after re-finding SOI.
    task automatic test_app0_payload();
        logic [31:0] words [8];
        logic [2:0]  exp   [8];
        words = '{32'hFFD8FFE0, 32'h0010FFDA, 32'h000C1122, 32'h33445566,
                  32'h778899AA, 32'hFFD9FFDA, 32'h000CFFD8, 32'hFFDA0002};
        exp   = '{3'b110, 3'b110, 3'b110, 3'b110,
                  3'b110, 3'b110, 3'b110, 3'b111};
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            send(words[i]);
            if ({jpeg_valid, found_app0, found_cutoff} !== exp[i]) begin
                $display("FAIL app0_payload[%0d] flags got %b want %b",
                         i, {jpeg_valid, found_app0, found_cutoff}, exp[i]);
                fail_count++;
            end
            assert_count++;
        end
    endtask

    // SOI, DQT(65 payload bytes, holding FF D9), DHT(4 bytes holding FF DA),
    // SOF0(9 bytes), SOS(10 bytes), then entropy data with marker-like bytes.
    // Total 116 bytes = 29 words; the 10th SOS byte is byte 105 -> word 26.
    task automatic test_full_header();
        logic [7:0]  q [$];
        logic [31:0] w;
        logic [2:0]  exp;
        q = {};
        q.push_back(8'hFF); q.push_back(8'hD8);
        q.push_back(8'hFF); q.push_back(8'hDB); q.push_back(8'h00); q.push_back(8'h43);
        for (int i = 0; i < 65; i++) begin
            if (i == 10)      q.push_back(8'hFF);
            else if (i == 11) q.push_back(8'hD9);
            else              q.push_back(8'(i));
        end
        q.push_back(8'hFF); q.push_back(8'hC4); q.push_back(8'h00); q.push_back(8'h06);
        q.push_back(8'h01); q.push_back(8'hFF); q.push_back(8'hDA); q.push_back(8'h02);
        q.push_back(8'hFF); q.push_back(8'hC0); q.push_back(8'h00); q.push_back(8'h0B);
        for (int i = 0; i < 9; i++) q.push_back(8'(8'h20 + i));
        q.push_back(8'hFF); q.push_back(8'hDA); q.push_back(8'h00); q.push_back(8'h0C);
        for (int i = 0; i < 10; i++) q.push_back(8'(8'h40 + i));
        q.push_back(8'hFF); q.push_back(8'hD9);
        q.push_back(8'h12); q.push_back(8'hFF); q.push_back(8'h00); q.push_back(8'h34);
        q.push_back(8'hFF); q.push_back(8'hD8); q.push_back(8'hFF); q.push_back(8'hE0);

        reset_dut();
        for (int wi = 0; wi < 29; wi++) begin
            w = {q[4*wi], q[4*wi+1], q[4*wi+2], q[4*wi+3]};
            send(w);
            exp = {1'b1, 1'b0, (wi >= 26)};
            if ({jpeg_valid, found_app0, found_cutoff} !== exp) begin
                $display("FAIL full_header[%0d] flags got %b want %b",
                         wi, {jpeg_valid, found_app0, found_cutoff}, exp);
                fail_count++;
            end
            assert_count++;
        end
    endtask

    // Fill bytes, TEM/RST standalone markers and a zero-payload APP0/SOS.
    task automatic test_standalone();
        logic [31:0] words [4];
        logic [2:0]  exp   [4];
        words = '{32'hFFD8FF01, 32'hFFD0FFFF, 32'hFFE00002, 32'hFFDA0002};
        exp   = '{3'b100, 3'b100, 3'b110, 3'b111};
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            send(words[i]);
            if ({jpeg_valid, found_app0, found_cutoff} !== exp[i]) begin
                $display("FAIL standalone[%0d] flags got %b want %b",
                         i, {jpeg_valid, found_app0, found_cutoff}, exp[i]);
                fail_count++;
            end
            assert_count++;
        end
    endtask

    // Lengths 0001 and 0000 are clamped to 2 (no payload to skip).
    task automatic test_len_clamp();
        logic [31:0] words [3];
        logic [2:0]  exp   [3];
        words = '{32'hFFD8FFDB, 32'h0001FFDA, 32'h0000ABCD};
        exp   = '{3'b100, 3'b100, 3'b101};
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            send(words[i]);
            if ({jpeg_valid, found_app0, found_cutoff} !== exp[i]) begin
                $display("FAIL len_clamp[%0d] flags got %b want %b",
                         i, {jpeg_valid, found_app0, found_cutoff}, exp[i]);
                fail_count++;
            end
            assert_count++;
        end
    endtask

    task automatic test_midreset();
        reset_dut();
        send(32'hFFD8FFDB);
        send(32'h00431111);
        if ({jpeg_valid, found_app0, found_cutoff} !== 3'b100) begin
            $display("FAIL midreset_pre flags got %b want 100",
                     {jpeg_valid, found_app0, found_cutoff});
            fail_count++;
        end
        assert_count++;
        #3;
        rst = 1'b0;       // asynchronous, between clock edges
        #1;
        if ({jpeg_valid, found_app0, found_cutoff} !== 3'b000) begin
            $display("FAIL midreset_async flags got %b want 000",
                     {jpeg_valid, found_app0, found_cutoff});
            fail_count++;
        end
        assert_count++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        send(32'h11111111);
        if (jpeg_valid !== 1'b0) begin
            $display("FAIL midreset_nosoi jv got %b want 0", jpeg_valid);
            fail_count++;
        end
        assert_count++;
        send(32'h0000FFD8);
        if ({jpeg_valid, found_app0, found_cutoff} !== 3'b100) begin
            $display("FAIL midreset_resoi flags got %b want 100",
                     {jpeg_valid, found_app0, found_cutoff});
            fail_count++;
        end
        assert_count++;
    endtask

    task automatic test_no_soi();
        logic [31:0] words [8];
        words = '{32'hFFD9FFE0, 32'hFFDA000C, 32'hD8FF00D8, 32'hFF00FFDA,
                  32'h12345678, 32'hFFC0FFE0, 32'hD9D8D8FF, 32'h00FFFFD9};
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            send(words[i]);
            if ({jpeg_valid, found_app0, found_cutoff} !== 3'b000) begin
                $display("FAIL no_soi[%0d] flags got %b want 000",
                         i, {jpeg_valid, found_app0, found_cutoff});
                fail_count++;
            end
            assert_count++;
        end
    endtask

    initial begin
        rst     = 1'b0;
        data_in = 32'h0;
        test_reset();
        test_soi_app0();
        test_split_soi();
        test_app0_payload();
        test_full_header();
        test_standalone();
        test_len_clamp();
        test_midreset();
        test_no_soi();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
